// File: rtl/dmem_responder.sv
// Word-addressed data memory answering one load/store at a time with a fixed LATENCY-cycle access.
// Response after LATENCY edges; busy while in flight, inputs ignored until the ready pulse, no queueing.
module dmem_responder #(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] adr,
   input  logic [31:0] data_in,
   output logic        busy,
   output logic        ready,
   output logic        err,
   output logic [31:0] data_out
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t         state, state_n;
   logic [3:0]     cnt, cnt_n;
   logic           busy_n, ready_n, err_n;
   logic [31:0]    dout_n;
   logic           we_q;
   logic [31:0]    adr_q, din_q;
   logic           accept, mem_wr, bad;
   logic [AW-1:0]  idx;
   logic [31:0]    mem [DEPTH];

   assign idx = adr_q[AW+1:2];
   // Misaligned or beyond the top word: the access never touches the array.
   assign bad = (adr_q[1:0] != 2'b00) || (adr_q[31:AW+2] != '0);

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      busy_n  = busy;
      ready_n = 1'b0;
      err_n   = 1'b0;
      dout_n  = data_out;
      accept  = 1'b0;
      mem_wr  = 1'b0;
      case (state)
         IDLE, RESP: begin
            if (req) begin
               accept  = 1'b1;
               cnt_n   = 4'(LATENCY - 1);
               busy_n  = 1'b1;
               state_n = WAIT;
            end else begin
               state_n = IDLE;
            end
         end
         WAIT: begin
            if (cnt != 4'd0) begin
               cnt_n = cnt - 4'd1;
            end else begin
               busy_n  = 1'b0;
               ready_n = 1'b1;
               state_n = RESP;
               if (bad) begin
                  err_n  = 1'b1;
                  dout_n = '0;
               end else if (we_q) begin
                  mem_wr = 1'b1;
                  dout_n = din_q;
               end else begin
                  dout_n = mem[idx];
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         busy     <= 1'b0;
         ready    <= 1'b0;
         err      <= 1'b0;
         data_out <= '0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         busy     <= busy_n;
         ready    <= ready_n;
         err      <= err_n;
         data_out <= dout_n;
      end
   end

   // Request fields are captured once so later input changes cannot disturb the in-flight access.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_q  <= 1'b0;
         adr_q <= '0;
         din_q <= '0;
      end else if (accept) begin
         we_q  <= we;
         adr_q <= adr;
         din_q <= data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_wr) mem[idx] <= din_q;
   end

endmodule
